// File: rtl/kmap_sweep_ctrl.sv
// rtl/kmap_sweep_ctrl.sv - exhaustive truth-table sweep and self-check sequencer
module kmap_sweep_ctrl #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   exp_table,
    input  logic [2**N_IN-1:0]   care_mask,
    output logic [N_IN-1:0]      fn_in,
    input  logic                 fn_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic                 first_err_vld,
    output logic [N_IN-1:0]      first_err_idx
);

    localparam int T  = 2**N_IN;
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [CW-1:0]   CNT_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   settle_cnt;
    logic [T-1:0]    exp_q;
    logic [T-1:0]    care_q;
    logic            mism;
    logic [N_IN:0]   err_nxt;

    // Case-inequality so an X/Z from the function block is flagged, not masked.
    always_comb begin
        mism    = 1'b0;
        mism    = care_q[fn_in] && (fn_out !== exp_q[fn_in]);
        err_nxt = err_count + {{N_IN{1'b0}}, mism};
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state         <= ST_IDLE;
            settle_cnt    <= '0;
            exp_q         <= '0;
            care_q        <= '0;
            fn_in         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        exp_q         <= exp_table;
                        care_q        <= care_mask;
                        err_count     <= '0;
                        first_err_vld <= 1'b0;
                        first_err_idx <= '0;
                        pass          <= 1'b0;
                        fn_in         <= '0;
                        settle_cnt    <= '0;
                        busy          <= 1'b1;
                        state         <= (SETTLE == 0) ? ST_SAMPLE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        fn_in      <= '0;
                        busy       <= 1'b0;
                        pass       <= 1'b0;
                        settle_cnt <= '0;
                    end else if (settle_cnt == CNT_LAST) begin
                        settle_cnt <= '0;
                        state      <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        fn_in      <= '0;
                        busy       <= 1'b0;
                        pass       <= 1'b0;
                        settle_cnt <= '0;
                    end else begin
                        err_count <= err_nxt;
                        if (mism && !first_err_vld) begin
                            first_err_vld <= 1'b1;
                            first_err_idx <= fn_in;
                        end
                        // Last vector: no wrap, report on the following cycle.
                        if (fn_in == VEC_LAST) begin
                            state <= ST_DONE;
                            fn_in <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt == '0);
                        end else begin
                            fn_in <= fn_in + 1'b1;
                            state <= (SETTLE == 0) ? ST_SAMPLE : ST_HOLD;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// tb/tb_kmap_sweep_ctrl.sv - directed self-checking bench for kmap_sweep_ctrl
module tb_kmap_sweep_ctrl;

    logic        clk;
    logic        areset;
    logic        start;
    logic        abort;
    logic [15:0] exp_table;
    logic [15:0] care_mask;
    logic [3:0]  fn_in;
    logic        fn_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic        first_err_vld;
    logic [3:0]  first_err_idx;

    logic [15:0] model;
    logic [1:0]  mode;
    int          total;
    int          bad;

    kmap_sweep_ctrl #(.N_IN(4), .SETTLE(2)) dut (
        .clk           (clk),
        .areset        (areset),
        .start         (start),
        .abort         (abort),
        .exp_table     (exp_table),
        .care_mask     (care_mask),
        .fn_in         (fn_in),
        .fn_out        (fn_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_vld (first_err_vld),
        .first_err_idx (first_err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function block stand-in: table model, stuck-0 or stuck-1.
    always_comb begin
        fn_out = 1'b0;
        case (mode)
            2'd1:    fn_out = 1'b0;
            2'd2:    fn_out = 1'b1;
            default: fn_out = model[fn_in];
        endcase
    end

    task automatic run_sweep(input int restart_at, input bit chg, output int cyc);
        bit pulsed;
        pulsed = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        if (chg) exp_table = ~exp_table;
        while (done !== 1'b1 && cyc < 200) begin
            if (!pulsed && restart_at >= 0 && int'(fn_in) == restart_at) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%0b want=0", pass); end
        total++; if (fn_in !== 4'd0) begin bad++; $display("FAIL reset_fn_in got=%0d want=0", fn_in); end
        total++; if (err_count !== 5'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_count); end
        total++; if (first_err_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b want=0", first_err_vld); end
        @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic test_golden;
        int cyc;
        mode = 2'd0; model = 16'hDD0C; exp_table = 16'hDD0C; care_mask = 16'hDDEF;
        run_sweep(-1, 1'b0, cyc);
        total++; if (cyc != 49) begin bad++; $display("FAIL golden_latency got=%0d want=49", cyc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL golden_busy got=%0b want=0", busy); end
        total++; if (fn_in !== 4'd0) begin bad++; $display("FAIL golden_fn_in got=%0d want=0", fn_in); end
        total++; if (err_count !== 5'd0) begin bad++; $display("FAIL golden_err got=%0d want=0", err_count); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL golden_pass got=%0b want=1", pass); end
        total++; if (first_err_vld !== 1'b0) begin bad++; $display("FAIL golden_vld got=%0b want=0", first_err_vld); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL golden_done_pulse got=%0b want=0", done); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL golden_pass_hold got=%0b want=1", pass); end
    endtask

    task automatic test_stuck0;
        int cyc;
        mode = 2'd1;
        run_sweep(-1, 1'b0, cyc);
        total++; if (cyc != 49) begin bad++; $display("FAIL s0_latency got=%0d want=49", cyc); end
        total++; if (err_count !== 5'd8) begin bad++; $display("FAIL s0_err got=%0d want=8", err_count); end
        total++; if (first_err_idx !== 4'd2) begin bad++; $display("FAIL s0_idx got=%0d want=2", first_err_idx); end
        total++; if (first_err_vld !== 1'b1) begin bad++; $display("FAIL s0_vld got=%0b want=1", first_err_vld); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL s0_pass got=%0b want=0", pass); end
    endtask

    task automatic test_stuck1;
        int cyc;
        mode = 2'd2;
        run_sweep(-1, 1'b0, cyc);
        total++; if (err_count !== 5'd5) begin bad++; $display("FAIL s1_err got=%0d want=5", err_count); end
        total++; if (first_err_idx !== 4'd0) begin bad++; $display("FAIL s1_idx got=%0d want=0", first_err_idx); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL s1_pass got=%0b want=0", pass); end
    endtask

    task automatic test_dont_care;
        int cyc;
        mode = 2'd0; model = 16'hDD0C ^ 16'h2210;
        run_sweep(-1, 1'b0, cyc);
        total++; if (err_count !== 5'd0) begin bad++; $display("FAIL dc_err got=%0d want=0", err_count); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL dc_pass got=%0b want=1", pass); end
        care_mask = 16'hFFFF;
        run_sweep(-1, 1'b0, cyc);
        total++; if (err_count !== 5'd3) begin bad++; $display("FAIL full_mask_err got=%0d want=3", err_count); end
        total++; if (first_err_idx !== 4'd4) begin bad++; $display("FAIL full_mask_idx got=%0d want=4", first_err_idx); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL full_mask_pass got=%0b want=0", pass); end
        care_mask = 16'hDDEF; model = 16'hDD0C;
    endtask

    task automatic test_restart_ignored;
        int cyc;
        mode = 2'd0;
        run_sweep(5, 1'b0, cyc);
        total++; if (cyc != 49) begin bad++; $display("FAIL restart_latency got=%0d want=49", cyc); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL restart_pass got=%0b want=1", pass); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_not_queued got=%0b want=0", busy); end
    endtask

    task automatic test_abort;
        int  n;
        bit  seen_done;
        mode = 2'd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (fn_in !== 4'd7 && n < 100) begin @(negedge clk); n++; end
        total++; if (fn_in !== 4'd7) begin bad++; $display("FAIL abort_reach7 got=%0d want=7", fn_in); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
        total++; if (fn_in !== 4'd0) begin bad++; $display("FAIL abort_fn_in got=%0d want=0", fn_in); end
        seen_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        total++; if (seen_done) begin bad++; $display("FAIL abort_no_done got=1 want=0"); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL abort_pass got=%0b want=0", pass); end
        total++; if (err_count !== 5'd2) begin bad++; $display("FAIL abort_partial_err got=%0d want=2", err_count); end
        total++; if (first_err_idx !== 4'd2) begin bad++; $display("FAIL abort_idx got=%0d want=2", first_err_idx); end
    endtask

    task automatic test_after_abort;
        int cyc;
        mode = 2'd0;
        run_sweep(-1, 1'b0, cyc);
        total++; if (cyc != 49) begin bad++; $display("FAIL post_abort_latency got=%0d want=49", cyc); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL post_abort_pass got=%0b want=1", pass); end
    endtask

    task automatic test_table_change;
        int cyc;
        mode = 2'd0;
        run_sweep(-1, 1'b1, cyc);
        total++; if (err_count !== 5'd0) begin bad++; $display("FAIL tbl_chg_err got=%0d want=0", err_count); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL tbl_chg_pass got=%0b want=1", pass); end
        exp_table = 16'hDD0C;
    endtask

    task automatic test_async_reset;
        mode = 2'd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (12) @(negedge clk);
        #1 areset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%0b want=0", busy); end
        total++; if (fn_in !== 4'd0) begin bad++; $display("FAIL areset_fn_in got=%0d want=0", fn_in); end
        total++; if (err_count !== 5'd0) begin bad++; $display("FAIL areset_err got=%0d want=0", err_count); end
        total++; if (first_err_vld !== 1'b0) begin bad++; $display("FAIL areset_vld got=%0b want=0", first_err_vld); end
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_stay_idle got=%0b want=0", busy); end
    endtask

    initial begin
        total = 0; bad = 0;
        areset = 1'b1; start = 1'b0; abort = 1'b0;
        exp_table = 16'hDD0C; care_mask = 16'hDDEF; model = 16'hDD0C; mode = 2'd0;
        test_reset;
        test_golden;
        test_stuck0;
        test_stuck1;
        test_dont_care;
        test_restart_ignored;
        test_abort;
        test_after_abort;
        test_table_change;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
